vga_timing: RTL

Pixel-timing generator for the 640x480@60 Hz display path. It divides the system clock down to the pixel rate and runs the horizontal and vertical scan counters. It drives the `col`/`row` coordinates consumed by every sprite/overlay stage (save buttons, kid, spikes, background), plus the VGA sync, blanking and per-frame strobe. A frame-rate tick is also provided for game logic (kid physics, trigger updates).

---
 rtl/vga_timing.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Pixel-timing generator for the 640x480@60 Hz display path. A clock divider
// produces a one-clk pixel strobe; horizontal/vertical scan counters advance on
// that strobe. Sync, blanking and an end-of-frame strobe are registered so they
// line up with the col/row coordinates they describe.
//
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst         in   asynchronous reset, active-low
//   pix_en      out  one-clk pixel strobe (divider at CLK_DIV-1)
//   col         out  [9:0] horizontal counter, 0..H_TOTAL-1
//   row         out  [9:0] vertical counter,   0..V_TOTAL-1
//   video_on    out  high while (col,row) is inside the active area
//   hs          out  horizontal sync, active-low
//   vs          out  vertical sync, active-low
//   frame_tick  out  one-clk pulse in the cycle after the (last,last)->(0,0) wrap
//
// Build option:
//   VGA_TIMING_ROM_ALIGN_EN  when defined, hs/vs/video_on pass through one more
//                            pixel-rate register so they line up with sprite ROM
//                            data that has one pixel of read latency. col, row,
//                            frame_tick and pix_en are not delayed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       video_on,
  output logic       hs,
  output logic       vs,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // All boundaries are expressed as inclusive "last" values so every constant
  // fits in the 10-bit counter range, even when a total reaches 1024.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       col_nxt;
  logic [9:0]       row_nxt;
  logic             video_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             video_q;
  logic             hs_q;
  logic             vs_q;

  assign pix_en = (div == DIV_LAST);

  // Next counter values, and the sync/blank levels that belong to them, so the
  // registered derived outputs are coincident with the registered counters.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    col_nxt = col;
    row_nxt = row;
    if (pix_en) begin
      if (col == H_LAST) begin
        col_nxt = '0;
        row_nxt = (row == V_LAST) ? '0 : row + 10'd1;
      end else begin
        col_nxt = col + 10'd1;
      end
    end
    video_nxt = (col_nxt <= H_ACT_LAST) && (row_nxt <= V_ACT_LAST);
    hs_nxt    = !((col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST));
    vs_nxt    = !((row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      col        <= '0;
      row        <= '0;
      video_q    <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      div        <= pix_en ? '0 : div + DIV_W'(1);
      // Set by the pixel edge that performs the full-frame wrap, so it is high
      // for exactly the one clk while the counters read (0,0).
      frame_tick <= pix_en && (col == H_LAST) && (row == V_LAST);
      if (pix_en) begin
        col     <= col_nxt;
        row     <= row_nxt;
        video_q <= video_nxt;
        hs_q    <= hs_nxt;
        vs_q    <= vs_nxt;
      end
    end
  end

`ifdef VGA_TIMING_ROM_ALIGN_EN
  logic video_d;
  logic hs_d;
  logic vs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      video_d <= 1'b0;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
    end else if (pix_en) begin
      video_d <= video_q;
      hs_d    <= hs_q;
      vs_d    <= vs_q;
    end
  end

  assign video_on = video_d;
  assign hs       = hs_d;
  assign vs       = vs_d;
`else
  assign video_on = video_q;
  assign hs       = hs_q;
  assign vs       = vs_q;
`endif

endmodule
